// File: rtl/cga_palette_dac.sv
// cga_palette_dac
//   Programmable palette / DAC stage between the CGA pixel pipeline and the
//   analog VGA port. A pixel index is looked up in a CPU-writable palette RAM
//   and the R/G/B DAC codes come out with a fixed two-clock latency. Sync is
//   delayed alongside the pixel path, and the blanking interval forces black.
//   After reset the RAM is filled with the standard 16-colour CGA table (with
//   colour 6 as brown), one entry per clock. Register writes are accepted once
//   that fill has finished.
//
//   Optional feature macro: CGA_PAL_READBACK_EN (palette readback via rd_re).
//
// Ports
//   clk        system clock
//   rst_n      synchronous reset, active low
//   video      pixel index
//   blank_in   1 = blanking interval
//   hsync_in   horizontal sync, aligned with video
//   vsync_in   vertical sync, aligned with video
//   red        red DAC code
//   green      green DAC code (COLOR_BITS+GREEN_EXTRA wide)
//   blue       blue DAC code
//   hsync      hsync_in delayed to match RGB
//   vsync      vsync_in delayed to match RGB
//   idx_we     load write/read index from wr_data[INDEX_BITS-1:0]
//   data_we    write one colour component from wr_data[COLOR_BITS-1:0]
//   wr_data    CPU write data
//   reg_ready  1 = register writes accepted
//   rd_re      read one colour component (readback build only)
//   rd_data    readback data (constant 0 without readback)

module cga_palette_dac #(
  parameter  int COLOR_BITS  = 6,
  parameter  int GREEN_EXTRA = 1,
  parameter  int INDEX_BITS  = 4,
  localparam int WD          = (COLOR_BITS > INDEX_BITS) ? COLOR_BITS : INDEX_BITS,
  localparam int GW          = COLOR_BITS + GREEN_EXTRA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] video,
  input  logic                  blank_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  output logic [COLOR_BITS-1:0] red,
  output logic [GW-1:0]         green,
  output logic [COLOR_BITS-1:0] blue,
  output logic                  hsync,
  output logic                  vsync,
  input  logic                  idx_we,
  input  logic                  data_we,
  input  logic [WD-1:0]         wr_data,
  output logic                  reg_ready,
  input  logic                  rd_re,
  output logic [COLOR_BITS-1:0] rd_data
);

  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam int TW    = 3 * COLOR_BITS;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    PH_R,
    PH_G,
    PH_B
  } phase_e;

  // Levels are defined on a 6-bit scale; place them MSB-aligned in the DAC
  // code, truncating narrow DACs and zero-filling wide ones.
  function automatic logic [COLOR_BITS-1:0] scaleLevel(input logic [5:0] l);
    logic [COLOR_BITS+5:0] wide;
    wide = {l, {COLOR_BITS{1'b0}}};
    return wide[COLOR_BITS+5 -: COLOR_BITS];
  endfunction

  // Standard CGA colour c as {R,G,B}: bits are I,R,G,B; intensity adds the
  // low level, and colour 6 gets a halved green to make brown.
  function automatic logic [TW-1:0] cgaDefault(input logic [3:0] c);
    logic [5:0] lo;
    logic [5:0] r6;
    logic [5:0] g6;
    logic [5:0] b6;
    lo = c[3] ? 6'h15 : 6'h00;
    r6 = (c[2] ? 6'h2A : 6'h00) + lo;
    g6 = (c[1] ? 6'h2A : 6'h00) + lo;
    b6 = (c[0] ? 6'h2A : 6'h00) + lo;
    if (c == 4'd6) begin
      g6 = 6'h15;
    end
    return {scaleLevel(r6), scaleLevel(g6), scaleLevel(b6)};
  endfunction

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] initCnt_q, initCnt_d;
  logic                  regReady_q, regReady_d;

  logic [INDEX_BITS-1:0] wrIndex_q, wrIndex_d;
  phase_e                wrPhase_q, wrPhase_d;
  logic [COLOR_BITS-1:0] rLatch_q, rLatch_d;
  logic [COLOR_BITS-1:0] gLatch_q, gLatch_d;

  logic                  ramWe;
  logic [INDEX_BITS-1:0] ramAddr;
  logic [TW-1:0]         ramWData;
  logic [TW-1:0]         palette [DEPTH];

  logic                  idxAccept;
  logic                  dataAccept;
  logic [3:0]            initColor;

  logic [TW-1:0]         pix1_q;
  logic                  blank1_q;
  logic                  hs1_q;
  logic                  vs1_q;
  logic [COLOR_BITS-1:0] pixR;
  logic [COLOR_BITS-1:0] pixG;
  logic [COLOR_BITS-1:0] pixB;
  logic [GW-1:0]         greenExt;

  logic [COLOR_BITS-1:0] red_q;
  logic [GW-1:0]         green_q;
  logic [COLOR_BITS-1:0] blue_q;
  logic                  hsync_q;
  logic                  vsync_q;

  // reg_ready is only ever set while in RUN, so it doubles as the write gate.
  assign idxAccept  = regReady_q & idx_we;
  assign dataAccept = regReady_q & data_we & ~idx_we;
  assign initColor  = 4'(initCnt_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      initCnt_q  <= '0;
      regReady_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      initCnt_q  <= initCnt_d;
      regReady_q <= regReady_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    initCnt_d  = initCnt_q;
    regReady_d = regReady_q;
    case (state_q)
      ST_INIT: begin
        initCnt_d = initCnt_q + 1'b1;
        if (initCnt_q == '1) begin
          state_d    = ST_RUN;
          regReady_d = 1'b1;
          initCnt_d  = '0;
        end
      end
      ST_RUN: begin
        regReady_d = 1'b1;
      end
      default: begin
        state_d    = ST_INIT;
        regReady_d = 1'b0;
      end
    endcase
  end

  // Components are staged until the blue write so the RAM only ever sees
  // complete triples; the single write port is shared with the init fill.
  always_comb begin
    wrIndex_d = wrIndex_q;
    wrPhase_d = wrPhase_q;
    rLatch_d  = rLatch_q;
    gLatch_d  = gLatch_q;
    ramWe     = (state_q == ST_INIT);
    ramAddr   = initCnt_q;
    ramWData  = cgaDefault(initColor);
    if (idxAccept) begin
      wrIndex_d = wr_data[INDEX_BITS-1:0];
      wrPhase_d = PH_R;
    end else if (dataAccept) begin
      case (wrPhase_q)
        PH_R: begin
          rLatch_d  = wr_data[COLOR_BITS-1:0];
          wrPhase_d = PH_G;
        end
        PH_G: begin
          gLatch_d  = wr_data[COLOR_BITS-1:0];
          wrPhase_d = PH_B;
        end
        PH_B: begin
          ramWe     = 1'b1;
          ramAddr   = wrIndex_q;
          ramWData  = {rLatch_q, gLatch_q, wr_data[COLOR_BITS-1:0]};
          wrIndex_d = wrIndex_q + 1'b1;
          wrPhase_d = PH_R;
        end
        default: begin
          wrPhase_d = PH_R;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrIndex_q <= '0;
      wrPhase_q <= PH_R;
      rLatch_q  <= '0;
      gLatch_q  <= '0;
    end else begin
      wrIndex_q <= wrIndex_d;
      wrPhase_q <= wrPhase_d;
      rLatch_q  <= rLatch_d;
      gLatch_q  <= gLatch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && ramWe) begin
      palette[ramAddr] <= ramWData;
    end
  end

  // Stage 1: registered RAM read; a same-cycle commit to the entry being
  // read is not visible until the following read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix1_q   <= '0;
      blank1_q <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
    end else begin
      pix1_q   <= palette[video];
      blank1_q <= blank_in;
      hs1_q    <= hsync_in;
      vs1_q    <= vsync_in;
    end
  end

  assign pixR = pix1_q[TW-1 -: COLOR_BITS];
  assign pixG = pix1_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign pixB = pix1_q[COLOR_BITS-1:0];

  // Extra green LSBs replicate the MSBs so full scale stays all-ones.
  generate
    if (GREEN_EXTRA == 0) begin : gNoExt
      assign greenExt = pixG;
    end else begin : gExt
      assign greenExt = {pixG, pixG[COLOR_BITS-1 -: GREEN_EXTRA]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      red_q   <= blank1_q ? '0 : pixR;
      green_q <= blank1_q ? '0 : greenExt;
      blue_q  <= blank1_q ? '0 : pixB;
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign reg_ready = regReady_q;

`ifdef CGA_PAL_READBACK_EN
  logic [INDEX_BITS-1:0] rdIndex_q, rdIndex_d;
  phase_e                rdPhase_q, rdPhase_d;
  logic [COLOR_BITS-1:0] rdData_q, rdData_d;
  logic [TW-1:0]         rdEntry;

  assign rdEntry = palette[rdIndex_q];

  // The read uses the RAM contents before this cycle's commit; an index load
  // takes priority over a read issued in the same cycle.
  always_comb begin
    rdIndex_d = rdIndex_q;
    rdPhase_d = rdPhase_q;
    rdData_d  = rdData_q;
    if (idxAccept) begin
      rdIndex_d = wr_data[INDEX_BITS-1:0];
      rdPhase_d = PH_R;
    end else if (regReady_q && rd_re) begin
      case (rdPhase_q)
        PH_R: begin
          rdData_d  = rdEntry[TW-1 -: COLOR_BITS];
          rdPhase_d = PH_G;
        end
        PH_G: begin
          rdData_d  = rdEntry[2*COLOR_BITS-1 -: COLOR_BITS];
          rdPhase_d = PH_B;
        end
        PH_B: begin
          rdData_d  = rdEntry[COLOR_BITS-1:0];
          rdPhase_d = PH_R;
          rdIndex_d = rdIndex_q + 1'b1;
        end
        default: begin
          rdPhase_d = PH_R;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdIndex_q <= '0;
      rdPhase_q <= PH_R;
      rdData_q  <= '0;
    end else begin
      rdIndex_q <= rdIndex_d;
      rdPhase_q <= rdPhase_d;
      rdData_q  <= rdData_d;
    end
  end

  assign rd_data = rdData_q;
`else
  logic unusedRdRe;
  assign unusedRdRe = rd_re;
  assign rd_data    = '0;
`endif

endmodule

// File: tb/tb_cga_palette_dac.sv
// tb_cga_palette_dac
//   Directed bench for cga_palette_dac with a behavioural palette model.
//   Expected pixel and readback results are queued when stimulus is applied
//   and compared when their due cycle arrives.

module tb_cga_palette_dac;

  localparam int CB = 6;
  localparam int GE = 1;
  localparam int IB = 4;
  localparam int WD = 6;

  localparam logic [5:0] DEF_R [16] = '{
    6'h00, 6'h00, 6'h00, 6'h00, 6'h2A, 6'h2A, 6'h2A, 6'h2A,
    6'h15, 6'h15, 6'h15, 6'h15, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
  localparam logic [5:0] DEF_G [16] = '{
    6'h00, 6'h00, 6'h2A, 6'h2A, 6'h00, 6'h00, 6'h15, 6'h2A,
    6'h15, 6'h15, 6'h3F, 6'h3F, 6'h15, 6'h15, 6'h3F, 6'h3F};
  localparam logic [5:0] DEF_B [16] = '{
    6'h00, 6'h2A, 6'h00, 6'h2A, 6'h00, 6'h2A, 6'h00, 6'h2A,
    6'h15, 6'h3F, 6'h15, 6'h3F, 6'h15, 6'h3F, 6'h15, 6'h3F};

  typedef struct {
    int          due;
    logic [5:0]  r;
    logic [6:0]  g;
    logic [5:0]  b;
    logic        hs;
    logic        vs;
  } pixExp_t;

  typedef struct {
    int          due;
    logic [5:0]  d;
  } rdExp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IB-1:0] video;
  logic          blank_in;
  logic          hsync_in;
  logic          vsync_in;
  logic [CB-1:0] red;
  logic [CB:0]   green;
  logic [CB-1:0] blue;
  logic          hsync;
  logic          vsync;
  logic          idx_we;
  logic          data_we;
  logic [WD-1:0] wr_data;
  logic          reg_ready;
  logic          rd_re;
  logic [CB-1:0] rd_data;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  logic [5:0] mR [16];
  logic [5:0] mG [16];
  logic [5:0] mB [16];
  logic       mReady;
  logic [3:0] mCnt;
  logic [3:0] mWrIdx;
  logic [3:0] mRdIdx;
  int         mPh;
  int         mRdPh;
  logic [5:0] mLatR;
  logic [5:0] mLatG;

  pixExp_t pixQ [$];
  rdExp_t  rdQ [$];

  always #5 clk = ~clk;

  cga_palette_dac #(
    .COLOR_BITS (CB),
    .GREEN_EXTRA(GE),
    .INDEX_BITS (IB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .video    (video),
    .blank_in (blank_in),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .hsync    (hsync),
    .vsync    (vsync),
    .idx_we   (idx_we),
    .data_we  (data_we),
    .wr_data  (wr_data),
    .reg_ready(reg_ready),
    .rd_re    (rd_re),
    .rd_data  (rd_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: update the model with the inputs seen at this edge, advance,
  // then compare everything that has come due.
  task automatic applyStimulus();
    pixExp_t pe;
    rdExp_t  re;
    if (rst_n && mReady) begin
      pe.due = cyc + 2;
      pe.r   = blank_in ? 6'h00 : mR[video];
      pe.g   = blank_in ? 7'h00 : {mG[video], mG[video][5]};
      pe.b   = blank_in ? 6'h00 : mB[video];
      pe.hs  = hsync_in;
      pe.vs  = vsync_in;
      pixQ.push_back(pe);
    end
    if (!rst_n) begin
      mReady = 1'b0;
      mCnt   = 4'h0;
      mWrIdx = 4'h0;
      mRdIdx = 4'h0;
      mPh    = 0;
      mRdPh  = 0;
      mLatR  = 6'h00;
      mLatG  = 6'h00;
      pixQ.delete();
      rdQ.delete();
    end else if (!mReady) begin
      mR[mCnt] = DEF_R[mCnt];
      mG[mCnt] = DEF_G[mCnt];
      mB[mCnt] = DEF_B[mCnt];
      if (mCnt == 4'hF) mReady = 1'b1;
      mCnt = mCnt + 4'h1;
    end else if (idx_we) begin
      mWrIdx = wr_data[3:0];
      mRdIdx = wr_data[3:0];
      mPh    = 0;
      mRdPh  = 0;
    end else begin
      if (rd_re) begin
        re.due = cyc + 1;
`ifdef CGA_PAL_READBACK_EN
        re.d = (mRdPh == 0) ? mR[mRdIdx] : (mRdPh == 1) ? mG[mRdIdx] : mB[mRdIdx];
        if (mRdPh == 2) begin
          mRdPh  = 0;
          mRdIdx = mRdIdx + 4'h1;
        end else begin
          mRdPh++;
        end
`else
        re.d = 6'h00;
`endif
        rdQ.push_back(re);
      end
      if (data_we) begin
        if (mPh == 0) begin
          mLatR = wr_data;
          mPh   = 1;
        end else if (mPh == 1) begin
          mLatG = wr_data;
          mPh   = 2;
        end else begin
          mR[mWrIdx] = mLatR;
          mG[mWrIdx] = mLatG;
          mB[mWrIdx] = wr_data;
          mWrIdx     = mWrIdx + 4'h1;
          mPh        = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    checkOutput("reg_ready", {31'd0, reg_ready}, {31'd0, mReady});
    while (pixQ.size() > 0 && pixQ[0].due == cyc) begin
      pe = pixQ.pop_front();
      checkOutput("red", {26'd0, red}, {26'd0, pe.r});
      checkOutput("green", {25'd0, green}, {25'd0, pe.g});
      checkOutput("blue", {26'd0, blue}, {26'd0, pe.b});
      checkOutput("hsync", {31'd0, hsync}, {31'd0, pe.hs});
      checkOutput("vsync", {31'd0, vsync}, {31'd0, pe.vs});
    end
    while (rdQ.size() > 0 && rdQ[0].due == cyc) begin
      re = rdQ.pop_front();
      checkOutput("rd_data", {26'd0, rd_data}, {26'd0, re.d});
    end
  endtask

  task automatic cpuIdx(input logic [5:0] v);
    idx_we = 1'b1; wr_data = v;
    applyStimulus();
    idx_we = 1'b0;
  endtask

  task automatic cpuData(input logic [5:0] v);
    data_we = 1'b1; wr_data = v;
    applyStimulus();
    data_we = 1'b0;
  endtask

  task automatic cpuIdxData(input logic [5:0] v);
    idx_we = 1'b1; data_we = 1'b1; wr_data = v;
    applyStimulus();
    idx_we = 1'b0; data_we = 1'b0;
  endtask

  task automatic cpuRead();
    rd_re = 1'b1;
    applyStimulus();
    rd_re = 1'b0;
  endtask

  task automatic cpuReadData(input logic [5:0] v);
    rd_re = 1'b1; data_we = 1'b1; wr_data = v;
    applyStimulus();
    rd_re = 1'b0; data_we = 1'b0;
  endtask

  task automatic showPixel(input logic [3:0] v, input logic b);
    video = v; blank_in = b;
    applyStimulus();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    rst_n = 1'b0; video = '0; blank_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    idx_we = 1'b0; data_we = 1'b0; wr_data = '0; rd_re = 1'b0;
    mReady = 1'b0; mCnt = 4'h0; mWrIdx = 4'h0; mRdIdx = 4'h0;
    mPh = 0; mRdPh = 0; mLatR = 6'h00; mLatG = 6'h00;
    for (int i = 0; i < 16; i++) begin
      mR[i] = 6'h00; mG[i] = 6'h00; mB[i] = 6'h00;
    end

    // Reset state.
    idle(3);
    checkOutput("rst_red", {26'd0, red}, 32'd0);
    checkOutput("rst_green", {25'd0, green}, 32'd0);
    checkOutput("rst_blue", {26'd0, blue}, 32'd0);
    checkOutput("rst_hsync", {31'd0, hsync}, 32'd0);
    checkOutput("rst_vsync", {31'd0, vsync}, 32'd0);
    checkOutput("rst_rd_data", {26'd0, rd_data}, 32'd0);

    // Init fill: reg_ready low for 16 clocks, then brown through the pipe.
    rst_n = 1'b1;
    idle(16);
    checkOutput("ready_after_init", {31'd0, reg_ready}, 32'd1);
    showPixel(4'h6, 1'b0);
    showPixel(4'hE, 1'b0);
    showPixel(4'hF, 1'b0);
    showPixel(4'h9, 1'b0);

    // Blanking and sync alignment.
    showPixel(4'hF, 1'b1);
    hsync_in = 1'b1; showPixel(4'hF, 1'b0);
    hsync_in = 1'b0; vsync_in = 1'b1; showPixel(4'h1, 1'b0);
    vsync_in = 1'b0; showPixel(4'h2, 1'b1);
    idle(3);

    // CPU writes to entry 3, auto-increment into entry 4.
    cpuIdx(6'h03);
    cpuData(6'h3F); cpuData(6'h00); cpuData(6'h11);
    showPixel(4'h3, 1'b0);
    cpuData(6'h01); cpuData(6'h02); cpuData(6'h03);
    showPixel(4'h4, 1'b0);
    showPixel(4'h3, 1'b0);

    // Commit and pixel read of the same entry in one cycle: old value first.
    cpuIdx(6'h07);
    cpuData(6'h0A); cpuData(6'h0B);
    video = 4'h7; blank_in = 1'b0;
    cpuData(6'h0C);
    showPixel(4'h7, 1'b0);
    idle(2);

    // Index wrap from F to 0, then idx_we beating data_we.
    cpuIdx(6'h0F);
    cpuData(6'h21); cpuData(6'h22); cpuData(6'h23);
    cpuData(6'h31); cpuData(6'h32); cpuData(6'h33);
    showPixel(4'hF, 1'b0);
    showPixel(4'h0, 1'b0);
    cpuIdx(6'h05);
    cpuData(6'h2B);
    cpuIdxData(6'h05);
    cpuData(6'h12); cpuData(6'h13); cpuData(6'h14);
    showPixel(4'h5, 1'b0);
    showPixel(4'h6, 1'b0);
    idle(2);

    // Reset mid-RUN after writing entry 1; writes during the refill are ignored.
    cpuIdx(6'h01);
    cpuData(6'h05); cpuData(6'h06); cpuData(6'h07);
    showPixel(4'h1, 1'b0);
    idle(2);
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpuIdx(6'h02);
      cpuData(6'h3E);
      cpuReadData(6'h3D);
    end
    idle(1);
    checkOutput("ready_after_reinit", {31'd0, reg_ready}, 32'd1);
    showPixel(4'h1, 1'b0);
    showPixel(4'h2, 1'b0);
    cpuData(6'h30); cpuData(6'h31); cpuData(6'h32);
    showPixel(4'h0, 1'b0);
    showPixel(4'h1, 1'b0);
    idle(2);

    // Readback (constant 0 when the feature is not built).
    cpuIdx(6'h03);
    cpuData(6'h3F); cpuData(6'h00); cpuData(6'h11);
    cpuIdx(6'h03);
    cpuRead(); cpuRead(); cpuRead();
    cpuRead();
    cpuIdx(6'h07);
    cpuData(6'h01); cpuData(6'h02);
    cpuRead(); cpuRead();
    cpuReadData(6'h03);
    cpuIdx(6'h07);
    cpuRead(); cpuRead(); cpuRead();
    showPixel(4'h7, 1'b0);
    showPixel(4'h3, 1'b0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
